polar_sc_decoder: RTL

//  Parametrised successive-cancellation (SC) polar decoder with one shared f/g processing element.
//  - Accepts one frame of CODE_LENGTH channel LLRs as a valid/ready stream.
//  - Decodes using a min-sum schedule, one LLR op per cycle.
//  - Returns the full decoded u-vector on a valid/ready output.
//  - Frozen set is a runtime port, not a fixed count, so one build serves any rate.

---
 rtl/polar_sc_decoder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/polar_sc_decoder.sv
`default_nettype none
// ============================================================================
// Module  : polar_sc_decoder
// Brief   : Successive-cancellation polar decoder, one shared min-sum f/g
//           element, runtime frozen set, valid/ready frame in and out.
// Revision: 1.0  initial release
// ============================================================================
module polar_sc_decoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int CODE_LENGTH = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_llr,
  input  logic [CODE_LENGTH-1:0] frozen_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CODE_LENGTH-1:0] out_bits,
  output logic                   busy
);

  localparam int c_LOGN = $clog2(CODE_LENGTH);
  localparam int c_IW   = c_LOGN + 1;
  localparam int c_NW   = 2 * CODE_LENGTH - 1;
  localparam logic signed [DATA_WIDTH-1:0] c_LLR_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] c_LLR_MIN = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [DATA_WIDTH-1:0] c_LLR_RAW = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH:0]   c_SUM_MAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [c_LOGN-1:0]            c_LAST    = c_LOGN'(CODE_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DECODE = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // LLR tree: stage s occupies words [2^s-1, 2^(s+1)-2]; channel LLRs are stage n.
  logic signed [DATA_WIDTH-1:0] r_llr [0:c_NW-1];
  logic [CODE_LENGTH-1:0] r_ps;
  logic [CODE_LENGTH-1:0] r_u;
  logic [CODE_LENGTH-1:0] r_frozen;
  logic [CODE_LENGTH-1:0] r_out_bits;
  logic                   r_out_valid;
  logic [c_LOGN-1:0]      r_beat;
  logic [c_LOGN-1:0]      r_leaf;
  logic [c_LOGN-1:0]      r_stage;
  logic [c_LOGN-1:0]      r_elem;

  logic                         w_in_hs;
  logic signed [DATA_WIDTH-1:0] w_in_clamped;
  logic [c_IW-1:0]              w_half;
  logic [c_IW-1:0]              w_wr_idx;
  logic [c_IW-1:0]              w_a_idx;
  logic [c_IW-1:0]              w_b_idx;
  logic signed [DATA_WIDTH-1:0] w_a;
  logic signed [DATA_WIDTH-1:0] w_b;
  logic signed [DATA_WIDTH-1:0] w_abs_a;
  logic signed [DATA_WIDTH-1:0] w_abs_b;
  logic signed [DATA_WIDTH-1:0] w_min;
  logic signed [DATA_WIDTH-1:0] w_f;
  logic signed [DATA_WIDTH:0]   w_sum;
  logic signed [DATA_WIDTH-1:0] w_g;
  logic signed [DATA_WIDTH-1:0] w_res;
  logic                         w_is_g;
  logic [c_LOGN-1:0]            w_ps_idx;
  logic                         w_psum;
  logic                         w_leaf_op;
  logic                         w_last_op;
  logic                         w_u;
  logic [c_LOGN-1:0]            w_nleaf;
  logic [c_LOGN-1:0]            w_nstage;
  logic [CODE_LENGTH-1:0]       w_ps_nxt;
  logic                         w_run;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign busy      = (r_state == S_LOAD) || (r_state == S_DECODE);
  assign out_valid = r_out_valid;
  assign out_bits  = r_out_bits;

  assign w_in_hs      = in_valid & in_ready;
  assign w_in_clamped = ($signed(in_llr) == c_LLR_RAW) ? c_LLR_MIN : $signed(in_llr);

  assign w_half   = c_IW'(1) << r_stage;
  assign w_wr_idx = w_half - c_IW'(1) + c_IW'(r_elem);
  assign w_a_idx  = (w_half << 1) - c_IW'(1) + c_IW'(r_elem);
  assign w_b_idx  = w_a_idx + w_half;
  assign w_a      = r_llr[w_a_idx];
  assign w_b      = r_llr[w_b_idx];

  // A node is a right child (g) when the leaf index has its stage bit set;
  // g only occurs at the top stage of a leaf's path, so the left sibling
  // starts exactly 2^s leaves before the current one.
  assign w_is_g   = |(r_leaf & c_LOGN'(w_half));
  assign w_ps_idx = r_leaf - c_LOGN'(w_half) + r_elem;
  assign w_psum   = r_ps[w_ps_idx];

  assign w_abs_a = w_a[DATA_WIDTH-1] ? -w_a : w_a;
  assign w_abs_b = w_b[DATA_WIDTH-1] ? -w_b : w_b;
  assign w_min   = (w_abs_a < w_abs_b) ? w_abs_a : w_abs_b;
  assign w_f     = (w_a[DATA_WIDTH-1] ^ w_b[DATA_WIDTH-1]) ? -w_min : w_min;

  assign w_sum = w_psum ? ($signed({w_b[DATA_WIDTH-1], w_b}) - $signed({w_a[DATA_WIDTH-1], w_a}))
                        : ($signed({w_b[DATA_WIDTH-1], w_b}) + $signed({w_a[DATA_WIDTH-1], w_a}));

  always_comb begin
    if (w_sum > c_SUM_MAX) begin
      w_g = c_LLR_MAX;
    end else if (w_sum < -c_SUM_MAX) begin
      w_g = c_LLR_MIN;
    end else begin
      w_g = w_sum[DATA_WIDTH-1:0];
    end
  end

  assign w_res     = w_is_g ? w_g : w_f;
  assign w_leaf_op = (r_state == S_DECODE) && (r_stage == '0);
  assign w_last_op = w_leaf_op && (r_leaf == c_LAST);
  assign w_u       = ~r_frozen[r_leaf] & w_res[DATA_WIDTH-1];
  assign w_nleaf   = r_leaf + c_LOGN'(1);

  always_comb begin
    w_nstage = '0;
    for (int s = c_LOGN - 1; s >= 0; s--) begin
      if (w_nleaf[s]) w_nstage = c_LOGN'(s);
    end
  end

  // Each completed right subtree folds into its left sibling: left ^= right,
  // cascading up while the leaf index has all low bits set.
  always_comb begin
    w_ps_nxt = r_ps;
    w_run    = 1'b1;
    if (w_leaf_op) begin
      w_ps_nxt[r_leaf] = w_u;
      for (int s = 0; s < c_LOGN; s++) begin
        w_run = w_run & r_leaf[s];
        for (int k = 0; k < CODE_LENGTH; k++) begin
          if (w_run && (((k >> s) & 1) == 0) && ((k >> (s + 1)) == (int'(r_leaf) >> (s + 1)))) begin
            w_ps_nxt[k] = w_ps_nxt[k] ^ w_ps_nxt[k + (1 << s)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_in_hs) w_state_nxt = S_LOAD;
      S_LOAD:   if (w_in_hs && (r_beat == c_LAST)) w_state_nxt = S_DECODE;
      S_DECODE: if (w_last_op) w_state_nxt = S_OUTPUT;
      S_OUTPUT: if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_NW; i++) r_llr[i] <= '0;
      r_ps        <= '0;
      r_u         <= '0;
      r_frozen    <= '0;
      r_out_bits  <= '0;
      r_out_valid <= 1'b0;
      r_beat      <= '0;
      r_leaf      <= '0;
      r_stage     <= '0;
      r_elem      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_in_hs) begin
            r_llr[c_IW'(CODE_LENGTH - 1) + c_IW'(r_beat)] <= w_in_clamped;
            r_beat <= r_beat + c_LOGN'(1);
            if (r_state == S_IDLE) r_frozen <= frozen_mask;
            if (r_beat == c_LAST) begin
              r_leaf  <= '0;
              r_stage <= c_LOGN'(c_LOGN - 1);
              r_elem  <= '0;
            end
          end
        end
        S_DECODE: begin
          r_llr[w_wr_idx] <= w_res;
          r_ps            <= w_ps_nxt;
          if (w_leaf_op) begin
            r_u[r_leaf] <= w_u;
            r_leaf      <= w_nleaf;
            r_stage     <= w_nstage;
            r_elem      <= '0;
          end else if (c_IW'(r_elem) == (w_half - c_IW'(1))) begin
            r_stage <= r_stage - c_LOGN'(1);
            r_elem  <= '0;
          end else begin
            r_elem <= r_elem + c_LOGN'(1);
          end
        end
        S_OUTPUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_bits  <= r_u;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
